// File: rtl/button_conditioner_pkg.sv
// Shared timing package: FSM state encoding, default 1 ms tick and button timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package button_conditioner_pkg;

    localparam int TICK_CLK_DIV_DEF    = 100000;
    localparam int DEBOUNCE_MS_DEF     = 20;
    localparam int REPEAT_DELAY_MS_DEF = 500;
    localparam int REPEAT_RATE_MS_DEF  = 100;

    // Wide enough for any delay up to 65 s of 1 ms ticks.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD_DELAY,
        HELD_REPEAT,
        RELEASE_WAIT
    } btn_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/button_conditioner_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks (wraps CLK_DIV-1 -> 0).
// Latency: tick asserted in the cycle the count sits at CLK_DIV-1.
// Backpressure: none, free-running.
module tick_gen
    import button_conditioner_pkg::*;
#(
    parameter int CLK_DIV = TICK_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: sync, tick-based debounce, press/release/auto-repeat pulses (repeat under BUTTON_AUTOREPEAT_EN).
// Latency: press_pulse DEBOUNCE_MS..DEBOUNCE_MS+1 ticks plus 3 clocks after a clean edge; all outputs registered.
// Backpressure: none; pulses are single-cycle strobes with no handshake.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLK_DIV         = TICK_CLK_DIV_DEF,
    parameter int DEBOUNCE_MS     = DEBOUNCE_MS_DEF,
    parameter int REPEAT_DELAY_MS = REPEAT_DELAY_MS_DEF,
    parameter int REPEAT_RATE_MS  = REPEAT_RATE_MS_DEF
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_MS);

    logic [1:0]       sync_q;
    logic             btn_sync;
    logic             tick;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_nxt, deb_inc;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign btn_sync = sync_q[1];

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .tick  (tick)
    );

    assign deb_inc = sat_inc(deb_cnt);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(REPEAT_DELAY_MS);
    localparam logic [CNT_W-1:0] RATE_LIM  = CNT_W'(REPEAT_RATE_MS);

    // Hold count freezes while a release is being qualified so a short
    // release glitch only shifts the repeat cadence, never restarts it.
    logic [CNT_W-1:0] hold_cnt, hold_nxt, hold_inc;
    btn_state_t       ret_state, ret_nxt;
    logic             repeat_nxt;

    assign hold_inc = sat_inc(hold_cnt);
`endif

    always_comb begin
        state_nxt   = state;
        deb_nxt     = deb_cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        hold_nxt    = hold_cnt;
        ret_nxt     = ret_state;
        repeat_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt = PRESS_WAIT;
                    deb_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (tick) begin
                    if (deb_inc >= DEB_LIM) begin
                        state_nxt = HELD_DELAY;
                        deb_nxt   = '0;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        hold_nxt  = '0;
`endif
                    end else begin
                        deb_nxt = deb_inc;
                    end
                end
            end
            HELD_DELAY: begin
                if (!btn_sync) begin
                    state_nxt = RELEASE_WAIT;
                    deb_nxt   = '0;
`ifdef BUTTON_AUTOREPEAT_EN
                    ret_nxt   = HELD_DELAY;
                end else if (tick) begin
                    if (hold_inc >= DELAY_LIM) begin
                        state_nxt  = HELD_REPEAT;
                        hold_nxt   = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        hold_nxt = hold_inc;
                    end
`endif
                end
            end
`ifdef BUTTON_AUTOREPEAT_EN
            HELD_REPEAT: begin
                if (!btn_sync) begin
                    state_nxt = RELEASE_WAIT;
                    deb_nxt   = '0;
                    ret_nxt   = HELD_REPEAT;
                end else if (tick) begin
                    if (hold_inc >= RATE_LIM) begin
                        hold_nxt   = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        hold_nxt = hold_inc;
                    end
                end
            end
`endif
            RELEASE_WAIT: begin
                if (btn_sync) begin
`ifdef BUTTON_AUTOREPEAT_EN
                    state_nxt = ret_state;
`else
                    state_nxt = HELD_DELAY;
`endif
                    deb_nxt   = '0;
                end else if (tick) begin
                    if (deb_inc >= DEB_LIM) begin
                        state_nxt   = IDLE;
                        deb_nxt     = '0;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        deb_nxt = deb_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
`ifdef BUTTON_AUTOREPEAT_EN
            step_pulse    <= press_nxt | repeat_nxt;
`else
            step_pulse    <= press_nxt;
`endif
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            hold_cnt     <= '0;
            ret_state    <= HELD_DELAY;
            repeat_pulse <= 1'b0;
        end else begin
            hold_cnt     <= hold_nxt;
            ret_state    <= ret_nxt;
            repeat_pulse <= repeat_nxt;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner at CLK_DIV=10, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5.
// Expected pulses (kind + cycle window) are queued at stimulus time and popped by the output monitor.
module tb_button_conditioner;

    localparam int CLK_DIV = 10;
    localparam int DEB     = 4;
    localparam int DLY     = 20;
    localparam int RATE    = 5;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;
    localparam int SLACK   = CLK_DIV + 3;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int step_total = 0;

    typedef struct {
        int kind;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];

    button_conditioner #(
        .CLK_DIV         (CLK_DIV),
        .DEBOUNCE_MS     (DEB),
        .REPEAT_DELAY_MS (DLY),
        .REPEAT_RATE_MS  (RATE)
    ) dut (
        .CLK100MHZ     (clk),
        .CPU_RESETN    (rst_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .step_pulse    (step_pulse)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; matches the DUT prescaler phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic string kname(input int k);
        if (k == K_PRESS) return "press";
        if (k == K_REL)   return "release";
        return "repeat";
    endfunction

    always @(negedge clk) begin
        logic [2:0] pv;
        exp_t       x;
        if (rst_n === 1'b1) begin
            n_checks++;
            if (step_pulse !== (press_pulse | repeat_pulse)) begin
                n_fail++;
                $display("FAIL step_or cyc=%0d: step_pulse=%b required %b", cyc, step_pulse, press_pulse | repeat_pulse);
            end
            n_checks++;
            if ((press_pulse & repeat_pulse) !== 1'b0) begin
                n_fail++;
                $display("FAIL press_repeat_excl cyc=%0d: both asserted, required not both", cyc);
            end
            if (step_pulse === 1'b1) step_total++;
            pv = {repeat_pulse, release_pulse, press_pulse};
            for (int k = 0; k < 3; k++) begin
                if (pv[k] === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_%s cyc=%0d: pulse seen, required none", kname(k), cyc);
                    end else begin
                        x = exp_q.pop_front();
                        if (x.kind != k || cyc < x.lo || cyc > x.hi) begin
                            n_fail++;
                            $display("FAIL pulse_order cyc=%0d: got %s, required %s in [%0d,%0d]",
                                     cyc, kname(k), kname(x.kind), x.lo, x.hi);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int kind, input int lo);
        exp_t x;
        x.kind = kind;
        x.lo   = lo;
        x.hi   = lo + SLACK;
        exp_q.push_back(x);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_align(output int e);
        do begin
            @(posedge clk);
            #1;
        end while (cyc % CLK_DIV != 0);
        e = cyc;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (btn_level !== 1'b0)     begin n_fail++; $display("FAIL reset_level: %b required 0", btn_level); end
        n_checks++; if (press_pulse !== 1'b0)   begin n_fail++; $display("FAIL reset_press: %b required 0", press_pulse); end
        n_checks++; if (release_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_release: %b required 0", release_pulse); end
        n_checks++; if (repeat_pulse !== 1'b0)  begin n_fail++; $display("FAIL reset_repeat: %b required 0", repeat_pulse); end
        n_checks++; if (step_pulse !== 1'b0)    begin n_fail++; $display("FAIL reset_step: %b required 0", step_pulse); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(30);
    endtask

    task automatic test_clean_press;
        int e;
        wait_align(e);
        btn_raw = 1'b1;
        push_exp(K_PRESS, e + DEB * CLK_DIV);
        wait_cycles(100);
        n_checks++;
        if (btn_level !== 1'b1) begin n_fail++; $display("FAIL clean_level_held: %b required 1", btn_level); end
        wait_cycles(50);
        btn_raw = 1'b0;
        push_exp(K_REL, e + 150 + DEB * CLK_DIV);
        wait_cycles(80);
        n_checks++;
        if (btn_level !== 1'b0) begin n_fail++; $display("FAIL clean_level_released: %b required 0", btn_level); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL clean_pending: %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_bounce;
        int e;
        wait_align(e);
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b1;
            wait_cycles((i % 2 == 0) ? CLK_DIV : 2 * CLK_DIV);
            btn_raw = 1'b0;
            wait_cycles(25);
            n_checks++;
            if (btn_level !== 1'b0) begin n_fail++; $display("FAIL bounce_level_%0d: %b required 0", i, btn_level); end
        end
        wait_cycles(80);
        n_checks++;
        if (btn_level !== 1'b0) begin n_fail++; $display("FAIL bounce_level_final: %b required 0", btn_level); end
    endtask

    task automatic test_hold_repeat;
        int e, s0;
        s0 = step_total;
        wait_align(e);
        btn_raw = 1'b1;
        push_exp(K_PRESS, e + DEB * CLK_DIV);
        if (AUTOREP) begin
            for (int t = DEB + DLY; t < 40; t += RATE) push_exp(K_REP, e + t * CLK_DIV);
        end
        wait_cycles(400);
        btn_raw = 1'b0;
        push_exp(K_REL, e + 400 + DEB * CLK_DIV);
        wait_cycles(80);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_pending: %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
        n_checks++;
        if (step_total - s0 != (AUTOREP ? 5 : 1)) begin
            n_fail++;
            $display("FAIL hold_step_count: %0d required %0d", step_total - s0, AUTOREP ? 5 : 1);
        end
    endtask

    task automatic test_release_glitch;
        int e;
        wait_align(e);
        btn_raw = 1'b1;
        push_exp(K_PRESS, e + 40);
        if (AUTOREP) begin
            push_exp(K_REP, e + 240);
            push_exp(K_REP, e + 290);
            // Two ticks of glitch freeze the hold count, pushing cadence out by 20 cycles.
            push_exp(K_REP, e + 360);
            push_exp(K_REP, e + 410);
            push_exp(K_REP, e + 460);
        end
        wait_cycles(300);
        btn_raw = 1'b0;
        wait_cycles(15);
        n_checks++;
        if (btn_level !== 1'b1) begin n_fail++; $display("FAIL glitch_level: %b required 1", btn_level); end
        wait_cycles(5);
        btn_raw = 1'b1;
        wait_cycles(180);
        btn_raw = 1'b0;
        push_exp(K_REL, e + 540);
        wait_cycles(80);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL glitch_pending: %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid_hold;
        int e;
        logic [4:0] outs;
        wait_align(e);
        btn_raw = 1'b1;
        push_exp(K_PRESS, e + 40);
        wait_cycles(100);
        n_checks++;
        if (btn_level !== 1'b1) begin n_fail++; $display("FAIL midhold_level_before: %b required 1", btn_level); end
        rst_n = 1'b0;
        #1;
        outs = {btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse};
        n_checks++;
        if (outs !== 5'b0) begin n_fail++; $display("FAIL midhold_async_clear: outputs=%b required 00000", outs); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(K_PRESS, 40);
        wait_cycles(100);
        n_checks++;
        if (btn_level !== 1'b1) begin n_fail++; $display("FAIL midhold_relevel: %b required 1", btn_level); end
        btn_raw = 1'b0;
        push_exp(K_REL, 140);
        wait_cycles(80);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midhold_pending: %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_release_glitch();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 100000: CLK100MHZ cycles per 1 ms sample tick.
REQ-002 SHALL provide parameter DEBOUNCE_MS, default 20: stable ticks required to accept a level change (range 1..255).
REQ-003 SHALL provide parameter REPEAT_DELAY_MS, default 500: hold ticks before the first auto-repeat.
REQ-004 SHALL provide parameter REPEAT_RATE_MS, default 100: ticks between subsequent auto-repeats.
REQ-005 SHALL have port CLK100MHZ, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port CPU_RESETN, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port btn_raw, input, 1 bit: asynchronous, bouncing push-button, active-high (e.g. BTNU).
REQ-008 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-009 SHALL have port press_pulse, output, 1 bit: one-cycle pulse on accepted press.
REQ-010 SHALL have port release_pulse, output, 1 bit: one-cycle pulse on accepted release.
REQ-011 SHALL have port repeat_pulse, output, 1 bit: one-cycle pulse per auto-repeat.
REQ-012 SHALL have port step_pulse, output, 1 bit: press_pulse OR repeat_pulse; drives up/down counting of minute/hour.

Function
REQ-013 SHALL pass btn_raw through a 2-flop synchronizer; only the synchronized value is used thereafter.
REQ-014 SHALL generate a one-cycle tick every CLK_DIV cycles from a free-running prescaler (wraps CLK_DIV-1 -> 0).
REQ-015 SHALL implement FSM states IDLE, PRESS_WAIT, HELD_DELAY, HELD_REPEAT, RELEASE_WAIT.
REQ-016 IDLE: sync=1 -> PRESS_WAIT, count cleared.
REQ-017 PRESS_WAIT: sync=0 at any cycle -> IDLE (bounce rejected); count reaches DEBOUNCE_MS ticks with sync=1 -> HELD_DELAY, btn_level<=1, press_pulse for 1 cycle.
REQ-018 HELD_DELAY: count reaches REPEAT_DELAY_MS ticks -> HELD_REPEAT with repeat_pulse; sync=0 -> RELEASE_WAIT.
REQ-019 HELD_REPEAT: every REPEAT_RATE_MS ticks emit repeat_pulse; sync=0 -> RELEASE_WAIT.
REQ-020 RELEASE_WAIT: sync=1 -> return to the held state it came from, with hold count preserved; DEBOUNCE_MS ticks with sync=0 -> IDLE, btn_level<=0, release_pulse for 1 cycle.
REQ-021 The tick counter SHALL count ticks only and SHALL saturate; it SHALL never wrap to produce a spurious pulse.
REQ-022 press_pulse and repeat_pulse SHALL never be asserted in the same cycle.
REQ-023 Latency: press_pulse SHALL occur between DEBOUNCE_MS and DEBOUNCE_MS+1 ms + 3 cycles after a clean edge.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 CPU_RESETN=0 SHALL asynchronously force FSM=IDLE, prescaler=0, counters=0, synchronizer=0, and all outputs=0.
REQ-026 Reset mid-hold SHALL produce no release_pulse; after deassertion a still-pressed button SHALL re-debounce and emit press_pulse.

Configuration
REQ-027 Macro BUTTON_AUTOREPEAT_EN defined: HELD_DELAY/HELD_REPEAT behaviour as above.
REQ-028 Macro BUTTON_AUTOREPEAT_EN undefined: repeat logic SHALL be omitted, repeat_pulse tied 0, and the accepted press SHALL go to a single HELD state (HELD_DELAY with no timeout).

Structure
REQ-029 The shared clock package SHALL hold the FSM state encoding and default timing constants (1 ms tick, 20/500/100 ms).
REQ-030 Prescaler SHALL be the sub-module tick_gen (parameter CLK_DIV, output tick), reusable by the 1 Hz timer.

Verification (CLK_DIV=10, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5)
REQ-031 Clean press held 15 ticks -> exactly one press_pulse about 40 cycles after edge; btn_level=1; no repeat_pulse.
REQ-032 Bounce: 1-2 tick glitches ×5 then stable 0 -> no pulses; btn_level stays 0.
REQ-033 Hold 40 ticks (macro defined) -> press at tick 4, repeats at ticks 24, 29, 34, 39; step_pulse=5 pulses total.
REQ-034 Release glitch of 2 ticks during HELD_REPEAT -> no release_pulse; repeat cadence resumes.
REQ-035 CPU_RESETN low for 3 cycles while held -> all outputs 0 immediately; press_pulse 4 ticks after release of reset.
REQ-036 Macro undefined, hold 40 ticks -> one press_pulse, repeat_pulse never asserted.
